// File: rtl/scanline_pingpong.sv
// Ping-pong scanline buffer: TIA writes the back bank while VGA reads the front bank, horizontally scaled.
// Latency: one cycle from rd_hpos to pix_color/pix_valid; the buffer is cleared for WIDTH cycles after reset.
// Backpressure: none. Writes at or beyond WIDTH are dropped, and a second commit before a swap pulses overrun.
module scanline_pingpong #(
  parameter int WIDTH      = 160,
  parameter int COLOR_BITS = 7,
  parameter int SCALE      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_xpos,
  input  logic [COLOR_BITS-1:0] wr_color,
  input  logic                  wr_eol,
  input  logic                  rd_line_start,
  input  logic [9:0]            rd_hpos,
  input  logic                  rd_display_on,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_valid,
  output logic                  ready,
  output logic                  overrun,
  output logic                  front_bank
);

  localparam int AW = $clog2(WIDTH);
  localparam int SH = $clog2(SCALE);
  localparam logic [9:0] WIDTH_L = 10'(WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [AW-1:0]           clr_addr;
  logic                    pending;

  logic [COLOR_BITS-1:0]   bank0 [WIDTH];
  logic [COLOR_BITS-1:0]   bank1 [WIDTH];

  logic                    run;
  logic                    swap;
  logic                    front_next;
  logic                    wr_hit;
  logic                    rd_hit;
  logic [9:0]              rd_idx;
  logic [AW-1:0]           wr_addr;
  logic [AW-1:0]           rd_addr;
  logic [COLOR_BITS-1:0]   rd_dat;

  // Swap decision, address decode, and front-bank read (post-swap bank selection)
  always_comb begin
    run        = (state == RUN);
    swap       = run && rd_line_start && (pending || wr_eol);
    front_next = front_bank ^ swap;
    wr_hit     = run && wr_en && ({2'b00, wr_xpos} < WIDTH_L);
    wr_addr    = wr_xpos[AW-1:0];
    rd_idx     = rd_hpos >> SH;
    rd_hit     = rd_display_on && (rd_idx < WIDTH_L);
    rd_addr    = rd_idx[AW-1:0];
    rd_dat     = front_next ? bank1[rd_addr] : bank0[rd_addr];
  end

  // Storage: zero both banks while clearing, otherwise write only the pre-swap back bank
  always_ff @(posedge clk) begin
    if (!run) begin
      bank0[clr_addr] <= '0;
      bank1[clr_addr] <= '0;
    end else if (wr_hit) begin
      if (front_bank) bank0[wr_addr] <= wr_color;
      else            bank1[wr_addr] <= wr_color;
    end
  end

  // Control FSM: clear sweep, then bank swapping, commit tracking and registered pixel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      front_bank <= 1'b0;
      pending    <= 1'b0;
      pix_color  <= '0;
      pix_valid  <= 1'b0;
      ready      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          pix_color <= '0;
          pix_valid <= 1'b0;
          overrun   <= 1'b0;
          clr_addr  <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready      <= 1'b1;
          front_bank <= front_next;
          // A newer commit before the reader swaps replaces the older one in place
          overrun    <= wr_eol && pending && !swap;
          if (swap)        pending <= 1'b0;
          else if (wr_eol) pending <= 1'b1;
          if (rd_hit) begin
            pix_color <= rd_dat;
            pix_valid <= 1'b1;
          end else begin
            pix_color <= '0;
            pix_valid <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_scanline_pingpong.sv
// Bench for scanline_pingpong: a behavioural line-buffer model is checked every cycle,
// with directed literal checks covering reset, swap, repeat, overrun, drop and mid-line reset.
// Inputs are driven on the falling edge, and outputs are sampled 1 time unit after the rising edge.
module tb_scanline_pingpong;
  localparam int W  = 160;
  localparam int CB = 7;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_xpos = '0;
  logic [CB-1:0] wr_color = '0;
  logic          wr_eol = 1'b0;
  logic          rd_line_start = 1'b0;
  logic [9:0]    rd_hpos = '0;
  logic          rd_display_on = 1'b0;
  logic [CB-1:0] pix_color;
  logic          pix_valid, ready, overrun, front_bank;

  scanline_pingpong #(.WIDTH(W), .COLOR_BITS(CB), .SCALE(SC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_xpos(wr_xpos), .wr_color(wr_color),
    .wr_eol(wr_eol), .rd_line_start(rd_line_start), .rd_hpos(rd_hpos),
    .rd_display_on(rd_display_on), .pix_color(pix_color), .pix_valid(pix_valid),
    .ready(ready), .overrun(overrun), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: two line arrays, which one is shown, and whether a finished line waits
  logic [CB-1:0] mbank [2][W];
  int            m_clr;
  bit            m_front, m_pend, m_swap, m_back, m_valid, m_ovr;
  logic [CB-1:0] m_color;
  int            m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) for (int i = 0; i < W; i++) mbank[b][i] = '0;
      m_clr = 0; m_front = 0; m_pend = 0; m_color = '0; m_valid = 0; m_ovr = 0;
    end else if (m_clr < W) begin
      m_clr++; m_color = '0; m_valid = 0; m_ovr = 0;
    end else begin
      m_back = !m_front;
      m_swap = rd_line_start && (m_pend || wr_eol);
      m_ovr  = wr_eol && m_pend && !m_swap;
      if (m_swap) begin m_front = !m_front; m_pend = 0; end
      else if (wr_eol) m_pend = 1;
      m_idx = int'(rd_hpos) / SC;
      if (rd_display_on && m_idx < W) begin m_color = mbank[m_front][m_idx]; m_valid = 1; end
      else begin m_color = '0; m_valid = 0; end
      if (wr_en && int'(wr_xpos) < W) mbank[m_back][wr_xpos] = wr_color;
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("ready",      ready,      (m_clr >= W));
    chk("front_bank", front_bank, m_front);
    chk("overrun",    overrun,    m_ovr);
    chk("pix_valid",  pix_valid,  m_valid);
    chk("pix_color",  pix_color,  m_color);
  end

  task automatic tick();
    @(negedge clk);
    wr_en = 0; wr_eol = 0; rd_line_start = 0;
  endtask

  task automatic write_line(input int kind);
    logic [7:0] v;
    for (int x = 0; x < W; x++) begin
      case (kind)
        0: v = 8'(x);
        1: v = 8'(127 - x);
        2: v = 8'(x * 3);
        default: v = 8'(x) ^ 8'h2a;
      endcase
      wr_en = 1; wr_xpos = 8'(x); wr_color = v[CB-1:0];
      tick();
    end
  endtask

  task automatic sweep(input bit ls, input int last);
    for (int h = 0; h <= last; h++) begin
      rd_hpos = 10'(h); rd_display_on = 1; rd_line_start = ls && (h == 0);
      tick();
    end
    rd_display_on = 0;
  endtask

  task automatic read_at(input int h, input logic [CB-1:0] exp, input string nm);
    rd_hpos = 10'(h); rd_display_on = 1;
    tick();
    chk(nm, pix_color, exp);
    chk({nm, "_valid"}, pix_valid, 1'b1);
    rd_display_on = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset and clear sweep
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (159) tick();
    chk("t1_ready_159", ready, 1'b0);
    tick();
    chk("t1_ready_160", ready, 1'b1);
    chk("t1_front", front_bank, 1'b0);
    sweep(0, 700);
    read_at(100, 7'd0, "t1_cleared");

    // Test 2: full line, commit, swap and scaled sweep
    write_line(0);
    wr_eol = 1; tick();
    sweep(1, 700);
    chk("t2_front", front_bank, 1'b1);
    read_at(13, 7'd3, "t2_h13");
    read_at(639, 7'd31 + 7'd128 - 7'd128 + 7'd0 + 7'd128, "t2_h639");

    // Test 3: no commit, so the front line repeats
    sweep(1, 700);
    chk("t3_front", front_bank, 1'b1);
    chk("t3_overrun", overrun, 1'b0);

    // Test 4: two commits without a line start -> overrun, newer line shown
    write_line(1);
    wr_eol = 1; tick();
    chk("t4_first_eol_ovr", overrun, 1'b0);
    write_line(2);
    wr_eol = 1; tick();
    chk("t4_overrun_pulse", overrun, 1'b1);
    tick();
    chk("t4_overrun_clear", overrun, 1'b0);
    chk("t4_front_before", front_bank, 1'b1);
    sweep(1, 700);
    chk("t4_front_after", front_bank, 1'b0);
    read_at(40, 7'd30, "t4_h40");

    // Test 5: commit and line start together, write in swap cycle, dropped write
    write_line(3);
    wr_eol = 1; rd_line_start = 1; rd_hpos = 0; rd_display_on = 1;
    wr_en = 1; wr_xpos = 8'd5; wr_color = 7'd99;
    tick();
    rd_display_on = 0;
    chk("t5_front", front_bank, 1'b1);
    chk("t5_overrun", overrun, 1'b0);
    wr_en = 1; wr_xpos = 8'd200; wr_color = 7'd5; tick();
    read_at(20, 7'd99, "t5_swapcycle_wr");
    read_at(24, 7'd6 ^ 7'h2a, "t5_h24");
    rd_hpos = 10'd24; rd_display_on = 0; tick();
    chk("t5_display_off", pix_valid, 1'b0);
    sweep(0, 700);

    // Test 6: reset mid-line with a commit pending
    write_line(0);
    wr_eol = 1; tick();
    for (int h = 0; h < 50; h++) begin
      rd_hpos = 10'(h); rd_display_on = 1; tick();
    end
    rst_n = 0;
    #1;
    chk("t6_valid_now", pix_valid, 1'b0);
    chk("t6_color_now", pix_color, 7'd0);
    chk("t6_ready_now", ready, 1'b0);
    chk("t6_front_now", front_bank, 1'b0);
    rd_display_on = 0;
    tick(); tick();
    rst_n = 1;
    repeat (W) tick();
    chk("t6_ready", ready, 1'b1);
    sweep(1, 700);
    chk("t6_front", front_bank, 1'b0);
    read_at(20, 7'd0, "t6_cleared");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
